// File: rtl/cp0_exc_regs_if.sv
// CP0 access bus: mtc0/mfc0 port from the pipeline plus exception/eret commit strobes.
// The master is the pipeline side, the slave is the CP0 register block.
interface cp0_exc_regs_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;

    modport master (
        output we_i, waddr_i, data_i, raddr_i,
        output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        input  data_o
    );

    modport slave (
        input  we_i, waddr_i, data_i, raddr_i,
        input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        output data_o
    );
endinterface

// File: rtl/cp0_exc_regs.sv
// CP0 register block with precise-exception entry, ERET, prescaled Count and timer interrupt.
// Optional macro CP0_WR_BYPASS_EN: mfc0 sees the value of a same-cycle mtc0 to the same register.
module cp0_exc_regs #(
    parameter int          NUM_HW_INT = 6,
    parameter int          TIMER_IP   = 7,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_exc_regs_if.slave         bus,
    input  logic [NUM_HW_INT-1:0] int_i,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           badvaddr_o,
    output logic                  timer_int_o,
    output logic                  int_pending_o
);

    localparam logic [4:0]  A_BADVADDR = 5'd8;
    localparam logic [4:0]  A_COUNT    = 5'd9;
    localparam logic [4:0]  A_COMPARE  = 5'd11;
    localparam logic [4:0]  A_STATUS   = 5'd12;
    localparam logic [4:0]  A_CAUSE    = 5'd13;
    localparam logic [4:0]  A_EPC      = 5'd14;
    localparam logic [4:0]  A_PRID     = 5'd15;
    localparam logic [4:0]  A_CONFIG   = 5'd16;

    localparam logic [31:0] STATUS_RST = 32'h10000000;
    localparam logic [3:0]  PRESC_LD   = 4'(COUNT_DIV - 1);

    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic [31:0]           r_status;
    logic [31:0]           r_epc;
    logic [31:0]           r_badvaddr;
    logic [3:0]            r_presc;
    logic                  r_timer;
    logic [NUM_HW_INT-1:0] r_ip_hw;
    logic [1:0]            r_ip_sw;
    logic                  r_cause_bd;
    logic                  r_cause_iv;
    logic                  r_cause_wp;
    logic [4:0]            r_exccode;

    logic                  w_wr_ok;
    logic                  w_tick;
    logic                  w_tmatch;
    logic                  w_exl;
    logic [31:0]           w_cause;
    logic [31:0]           w_rdata;

    // mtc0 is dropped whenever an exception or eret commits in the same cycle
    assign w_wr_ok  = bus.we_i & ~bus.exc_valid_i & ~bus.eret_i;
    assign w_tick   = (r_presc == 4'd0);
    assign w_tmatch = (r_count == r_compare) && (r_compare != 32'd0);
    assign w_exl    = r_status[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 32'd0;
            r_presc <= PRESC_LD;
        end else if (w_wr_ok && bus.waddr_i == A_COUNT) begin
            r_count <= bus.data_i;
            r_presc <= PRESC_LD;
        end else if (w_tick) begin
            r_count <= r_count + 32'd1;
            r_presc <= PRESC_LD;
        end else begin
            r_presc <= r_presc - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_compare <= 32'd0;
            r_timer   <= 1'b0;
        end else if (w_wr_ok && bus.waddr_i == A_COMPARE) begin
            r_compare <= bus.data_i;
            r_timer   <= 1'b0;
        end else if (w_tmatch) begin
            r_timer   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= STATUS_RST;
        end else if (bus.exc_valid_i) begin
            r_status[1] <= 1'b1;
        end else if (bus.eret_i) begin
            r_status[1] <= 1'b0;
        end else if (w_wr_ok && bus.waddr_i == A_STATUS) begin
            r_status <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc      <= 32'd0;
            r_cause_bd <= 1'b0;
        end else if (bus.exc_valid_i) begin
            // nested exceptions keep the original return point
            if (!w_exl) begin
                r_epc      <= bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
                r_cause_bd <= bus.exc_bd_i;
            end
        end else if (w_wr_ok && bus.waddr_i == A_EPC) begin
            r_epc <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exccode  <= 5'd0;
            r_badvaddr <= 32'd0;
        end else if (bus.exc_valid_i) begin
            r_exccode <= bus.exc_code_i;
            if (bus.exc_code_i == 5'd4 || bus.exc_code_i == 5'd5)
                r_badvaddr <= bus.exc_badvaddr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ip_sw    <= 2'b00;
            r_cause_iv <= 1'b0;
            r_cause_wp <= 1'b0;
        end else if (w_wr_ok && bus.waddr_i == A_CAUSE) begin
            r_ip_sw    <= bus.data_i[9:8];
            r_cause_iv <= bus.data_i[23];
            r_cause_wp <= bus.data_i[22];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ip_hw <= '0;
        else      r_ip_hw <= int_i;
    end

    always_comb begin
        w_cause                     = 32'd0;
        w_cause[31]                 = r_cause_bd;
        w_cause[23]                 = r_cause_iv;
        w_cause[22]                 = r_cause_wp;
        w_cause[9:8]                = r_ip_sw;
        w_cause[6:2]                = r_exccode;
        w_cause[10 +: NUM_HW_INT]   = r_ip_hw;
        w_cause[8 + TIMER_IP]       = w_cause[8 + TIMER_IP] | r_timer;
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus.raddr_i)
            A_BADVADDR: w_rdata = r_badvaddr;
            A_COUNT:    w_rdata = r_count;
            A_COMPARE:  w_rdata = r_compare;
            A_STATUS:   w_rdata = r_status;
            A_CAUSE:    w_rdata = w_cause;
            A_EPC:      w_rdata = r_epc;
            A_PRID:     w_rdata = PRID_VAL;
            A_CONFIG:   w_rdata = CONFIG_VAL;
            default:    w_rdata = 32'd0;
        endcase
    end

`ifdef CP0_WR_BYPASS_EN
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;
    logic [31:0] w_cause_wr;

    assign w_cause_wr = (w_cause & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);

    always_comb begin
        bus.data_o = w_rdata;
        if (w_wr_ok && bus.waddr_i == bus.raddr_i) begin
            case (bus.waddr_i)
                A_COUNT, A_COMPARE, A_STATUS, A_EPC: bus.data_o = bus.data_i;
                A_CAUSE:                             bus.data_o = w_cause_wr;
                default:                             bus.data_o = w_rdata;
            endcase
        end
    end
`else
    assign bus.data_o = w_rdata;
`endif

    assign count_o       = r_count;
    assign compare_o     = r_compare;
    assign status_o      = r_status;
    assign cause_o       = w_cause;
    assign epc_o         = r_epc;
    assign badvaddr_o    = r_badvaddr;
    assign timer_int_o   = r_timer;
    assign int_pending_o = r_status[0] & ~w_exl & |(w_cause[15:8] & r_status[15:8]);

endmodule

// File: tb/tb_cp0_exc_regs.sv
// Directed self-checking bench for cp0_exc_regs (COUNT_DIV=2, default interrupt mapping).
module tb_cp0_exc_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  int_i = '0;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o, int_pending_o;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_exc_regs_if bus();

    cp0_exc_regs #(
        .NUM_HW_INT (6),
        .TIMER_IP   (7),
        .COUNT_DIV  (2),
        .PRID_VAL   (32'h004C0102),
        .CONFIG_VAL (32'h00008000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .int_i         (int_i),
        .count_o       (count_o),
        .compare_o     (compare_o),
        .status_o      (status_o),
        .cause_o       (cause_o),
        .epc_o         (epc_o),
        .badvaddr_o    (badvaddr_o),
        .timer_int_o   (timer_int_o),
        .int_pending_o (int_pending_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.data_i = '0; bus.raddr_i = '0;
        bus.exc_valid_i = 1'b0; bus.exc_code_i = '0; bus.exc_pc_i = '0;
        bus.exc_bd_i = 1'b0; bus.exc_badvaddr_i = '0; bus.eret_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        int_i = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
        tick();
        bus.we_i = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic [31:0] bva);
        bus.exc_valid_i = 1'b1; bus.exc_code_i = code; bus.exc_pc_i = pc;
        bus.exc_bd_i = bd; bus.exc_badvaddr_i = bva;
        tick();
        bus.exc_valid_i = 1'b0;
    endtask

    task automatic eret();
        bus.eret_i = 1'b1;
        tick();
        bus.eret_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
        logic [31:0] exps  [9] = '{32'h0, 32'h0, 32'h0, 32'h10000000, 32'h0, 32'h0,
                                   32'h004C0102, 32'h00008000, 32'h0};
        rst = 1'b0;
        idle_bus();
        #3;
        for (int i = 0; i < 9; i++) begin
            bus.raddr_i = addrs[i];
            #1;
            n_tests++;
            if (bus.data_o !== exps[i]) begin
                n_fail++;
                $display("FAIL reset_read[%0d] got %h expected %h", addrs[i], bus.data_o, exps[i]);
            end
        end
        n_tests++;
        if (timer_int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_timer got %b expected 0", timer_int_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_masks();
        do_reset();
        mtc0(5'd13, 32'hFFFFFFFF);
        mtc0(5'd15, 32'h0);
        mtc0(5'd16, 32'h0);
        mtc0(5'd8,  32'hFFFFFFFF);
        bus.raddr_i = 5'd13; #1;
        n_tests++;
        if (bus.data_o !== 32'h00C00300) begin
            n_fail++; $display("FAIL cause_mask got %h expected 00c00300", bus.data_o);
        end
        bus.raddr_i = 5'd15; #1;
        n_tests++;
        if (bus.data_o !== 32'h004C0102) begin
            n_fail++; $display("FAIL prid_ro got %h expected 004c0102", bus.data_o);
        end
        bus.raddr_i = 5'd16; #1;
        n_tests++;
        if (bus.data_o !== 32'h00008000) begin
            n_fail++; $display("FAIL config_ro got %h expected 00008000", bus.data_o);
        end
        bus.raddr_i = 5'd8; #1;
        n_tests++;
        if (bus.data_o !== 32'h0) begin
            n_fail++; $display("FAIL badvaddr_ro got %h expected 0", bus.data_o);
        end
        bus.raddr_i = 5'd31; #1;
        n_tests++;
        if (bus.data_o !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_31 got %h expected 0", bus.data_o);
        end
    endtask

    task automatic test_count_timer();
        do_reset();
        mtc0(5'd9, 32'h10);
        n_tests++;
        if (count_o !== 32'h10) begin
            n_fail++; $display("FAIL count_load got %h expected 10", count_o);
        end
        mtc0(5'd11, 32'h14);
        n_tests++;
        if (count_o !== 32'h10) begin
            n_fail++; $display("FAIL count_prescaled got %h expected 10", count_o);
        end
        repeat (7) tick();
        n_tests++;
        if (count_o !== 32'h14) begin
            n_fail++; $display("FAIL count_8cyc got %h expected 14", count_o);
        end
        n_tests++;
        if (timer_int_o !== 1'b0) begin
            n_fail++; $display("FAIL timer_early got %b expected 0", timer_int_o);
        end
        tick();
        n_tests++;
        if (timer_int_o !== 1'b1) begin
            n_fail++; $display("FAIL timer_set got %b expected 1", timer_int_o);
        end
        n_tests++;
        if (cause_o[15] !== 1'b1) begin
            n_fail++; $display("FAIL cause_ip7 got %b expected 1", cause_o[15]);
        end
        tick();
        n_tests++;
        if (timer_int_o !== 1'b1 || count_o !== 32'h15) begin
            n_fail++; $display("FAIL timer_sticky got %b/%h expected 1/15", timer_int_o, count_o);
        end
        mtc0(5'd11, 32'h100);
        n_tests++;
        if (timer_int_o !== 1'b0 || cause_o[15] !== 1'b0) begin
            n_fail++; $display("FAIL timer_clear got %b/%b expected 0/0", timer_int_o, cause_o[15]);
        end
    endtask

    task automatic test_exception();
        exc(5'd4, 32'hBFC00100, 1'b1, 32'h1233);
        n_tests++;
        if (epc_o !== 32'hBFC000FC) begin
            n_fail++; $display("FAIL exc_epc got %h expected bfc000fc", epc_o);
        end
        n_tests++;
        if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4) begin
            n_fail++; $display("FAIL exc_cause got %h expected bd=1 code=4", cause_o);
        end
        n_tests++;
        if (badvaddr_o !== 32'h1233 || status_o[1] !== 1'b1) begin
            n_fail++; $display("FAIL exc_bva_exl got %h/%b expected 1233/1", badvaddr_o, status_o[1]);
        end
        exc(5'd8, 32'h80000000, 1'b0, 32'h5555);
        n_tests++;
        if (epc_o !== 32'hBFC000FC || cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b1) begin
            n_fail++; $display("FAIL nested_exc got epc %h cause %h expected bfc000fc code 8 bd 1",
                               epc_o, cause_o);
        end
        n_tests++;
        if (badvaddr_o !== 32'h1233) begin
            n_fail++; $display("FAIL nested_bva got %h expected 1233", badvaddr_o);
        end
        eret();
        n_tests++;
        if (status_o[1] !== 1'b0) begin
            n_fail++; $display("FAIL eret_exl got %b expected 0", status_o[1]);
        end
    endtask

    task automatic test_priority();
        bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'hDEAD;
        bus.eret_i = 1'b1;
        exc(5'd0, 32'h80000180, 1'b0, 32'h0);
        bus.we_i = 1'b0; bus.eret_i = 1'b0;
        n_tests++;
        if (status_o[1] !== 1'b1 || epc_o !== 32'h80000180) begin
            n_fail++; $display("FAIL prio_exc got exl %b epc %h expected 1 80000180", status_o[1], epc_o);
        end
        bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'hDEAD;
        eret();
        bus.we_i = 1'b0;
        n_tests++;
        if (status_o[1] !== 1'b0 || epc_o !== 32'h80000180) begin
            n_fail++; $display("FAIL prio_eret got exl %b epc %h expected 0 80000180", status_o[1], epc_o);
        end
    endtask

    task automatic test_int_pending();
        mtc0(5'd12, 32'h0000FC01);
        int_i = 6'b000100;
        tick();
        n_tests++;
        if (int_pending_o !== 1'b1) begin
            n_fail++; $display("FAIL intp_on got %b expected 1", int_pending_o);
        end
        exc(5'd0, 32'h80001000, 1'b0, 32'h0);
        n_tests++;
        if (int_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL intp_exl got %b expected 0", int_pending_o);
        end
        eret();
        n_tests++;
        if (int_pending_o !== 1'b1) begin
            n_fail++; $display("FAIL intp_eret got %b expected 1", int_pending_o);
        end
        mtc0(5'd12, 32'h0000EC01);
        n_tests++;
        if (int_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL intp_masked got %b expected 0", int_pending_o);
        end
    endtask

    task automatic test_async_reset();
        mtc0(5'd11, 32'h3);
        mtc0(5'd9,  32'h3);
        tick();
        n_tests++;
        if (timer_int_o !== 1'b1) begin
            n_fail++; $display("FAIL ar_timer_pre got %b expected 1", timer_int_o);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (count_o !== 32'h0 || compare_o !== 32'h0 || timer_int_o !== 1'b0) begin
            n_fail++; $display("FAIL ar_count_timer got %h/%h/%b expected 0/0/0",
                               count_o, compare_o, timer_int_o);
        end
        n_tests++;
        if (status_o !== 32'h10000000 || cause_o !== 32'h0 || epc_o !== 32'h0
            || badvaddr_o !== 32'h0 || int_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL ar_regs got st %h ca %h epc %h bva %h ip %b expected reset",
                               status_o, cause_o, epc_o, badvaddr_o, int_pending_o);
        end
        int_i = '0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (count_o !== 32'h1) begin
            n_fail++; $display("FAIL ar_presc_restart got %h expected 1", count_o);
        end
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_write_masks();
        test_count_timer();
        test_exception();
        test_priority();
        test_int_pending();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
